// File: rtl/matrix_alu.sv
// matrix_alu: memory-mapped 4x4 matrix ALU (multiply one row per clock, add, subtract)
module matrix_alu #(
  parameter logic [7:0] BASE = 8'h20,
  parameter int ELEM_W = 16
) (
  input  logic                   Clk,
  input  logic                   nReset,
  input  logic [15:0]            address,
  input  logic                   nRead,
  input  logic                   nWrite,
  input  logic [16*ELEM_W-1:0]   ExeDataOut,
  output logic [16*ELEM_W-1:0]   MatrixDataOut,
  output logic                   Complete
);
  typedef enum logic [1:0] {IDLE, CALC, MUL} state_e;
  typedef logic [3:0][3:0][ELEM_W-1:0] mat_t;
  state_e state, state_n;
  mat_t a, b, acc, result, sum;
  logic [3:0][ELEM_W-1:0] mrow;
  logic [1:0] row;
  logic sub, prev_hit, valid, busy, cmd_hit, accept, wr, rd;
  assign valid   = address[15:8] == BASE && address[7:4] < 4'd3;
  assign busy    = state != IDLE;
  assign wr      = valid && !nWrite && !busy;
  assign rd      = valid && !nRead && nWrite && address[3:0] == 4'd2;
  assign cmd_hit = valid && address[3:0] == 4'd3 && nRead && nWrite;
  // prev_hit makes a held command address trigger only once
  assign accept  = cmd_hit && !prev_hit && !busy;
  always_comb begin
    sum = '0;
    mrow = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        sum[i][j] = sub ? a[i][j] - b[i][j] : a[i][j] + b[i][j];
        mrow[j] = mrow[j] + a[row][i] * b[i][j];
      end
  end
  always_comb
    state_n = state == IDLE ? (accept ? (address[7:4] == 4'd0 ? MUL : CALC) : IDLE)
            : state == MUL && row != 2'd3 ? MUL : IDLE;
  always_ff @(posedge Clk or negedge nReset)
    if (!nReset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge Clk or negedge nReset)
    if (!nReset) begin
      a <= '0;
      b <= '0;
      acc <= '0;
      result <= '0;
      row <= '0;
      sub <= 1'b0;
      prev_hit <= 1'b0;
      MatrixDataOut <= '0;
      Complete <= 1'b0;
    end else begin
      prev_hit <= cmd_hit;
      MatrixDataOut <= rd ? result : '0;
      if (wr && address[3:0] == 4'd0) a <= ExeDataOut;
      if (wr && address[3:0] == 4'd1) b <= ExeDataOut;
      if (accept) begin
        Complete <= 1'b0;
        sub <= address[7:4] == 4'd2;
        row <= '0;
      end
      if (state == CALC) begin
        result <= sum;
        Complete <= 1'b1;
      end
      if (state == MUL) begin
        acc[row] <= mrow;
        row <= row + 2'd1;
        // last row goes straight into result so the whole matrix lands in one edge
        if (row == 2'd3) begin
          result <= {mrow, acc[2:0]};
          Complete <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_matrix_alu.sv
// tb_matrix_alu: directed checks of matrix_alu bus decode, arithmetic and timing
module tb_matrix_alu;
  logic Clk = 0, nReset = 1, nRead = 1, nWrite = 1;
  logic [15:0] address = '0;
  logic [255:0] ExeDataOut = '0, MatrixDataOut;
  logic Complete;
  int checks = 0, errors = 0;
  logic [255:0] seq, ident;

  matrix_alu dut (
    .Clk(Clk), .nReset(nReset), .address(address), .nRead(nRead), .nWrite(nWrite),
    .ExeDataOut(ExeDataOut), .MatrixDataOut(MatrixDataOut), .Complete(Complete)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] fill(input logic [15:0] v);
    return {16{v}};
  endfunction

  task automatic wr(input logic [15:0] a, input logic [255:0] d);
    address = a; ExeDataOut = d; nWrite = 0;
    @(negedge Clk);
    nWrite = 1; address = '0;
  endtask

  task automatic cmd(input logic [15:0] a);
    address = a;
    @(negedge Clk);
    address = '0;
  endtask

  task automatic rd(input logic [15:0] a);
    address = a; nRead = 0;
    @(negedge Clk);
    nRead = 1; address = '0;
  endtask

  initial begin
    seq = '0;
    ident = '0;
    for (int i = 0; i < 16; i++) seq[16*i +: 16] = 16'(i + 1);
    for (int i = 0; i < 4; i++) ident[16*5*i +: 16] = 16'h0001;
    #2 nReset = 0;
    @(negedge Clk);
    chk("rst_dout", MatrixDataOut, '0);
    chk("rst_cplt", 256'(Complete), 0);
    nReset = 1;
    @(negedge Clk);

    // ADD wrap
    wr(16'h2010, fill(16'hFFFF));
    wr(16'h2011, fill(16'h0002));
    cmd(16'h2013);
    chk("add_k_cplt", 256'(Complete), 0);
    @(negedge Clk);
    chk("add_k1_cplt", 256'(Complete), 1);
    rd(16'h2012);
    chk("add_res", MatrixDataOut, fill(16'h0001));
    @(negedge Clk);
    chk("rd_release", MatrixDataOut, '0);

    // SUB underflow, command address held so it must not retrigger
    wr(16'h2020, '0);
    wr(16'h2021, fill(16'h0001));
    address = 16'h2023;
    @(negedge Clk);
    chk("sub_k_cplt", 256'(Complete), 0);
    @(negedge Clk);
    chk("sub_k1_cplt", 256'(Complete), 1);
    repeat (2) @(negedge Clk);
    chk("sub_hold_cplt", 256'(Complete), 1);
    address = '0;
    rd(16'h2022);
    chk("sub_res", MatrixDataOut, fill(16'hFFFF));

    // MUL identity with stale read at k+2
    wr(16'h2000, seq);
    wr(16'h2001, ident);
    cmd(16'h2003);
    chk("mul_k_cplt", 256'(Complete), 0);
    @(negedge Clk);
    rd(16'h2002);
    chk("mul_stale", MatrixDataOut, fill(16'hFFFF));
    chk("mul_k2_cplt", 256'(Complete), 0);
    @(negedge Clk);
    chk("mul_k3_cplt", 256'(Complete), 0);
    @(negedge Clk);
    chk("mul_k4_cplt", 256'(Complete), 1);
    rd(16'h2002);
    chk("mul_ident", MatrixDataOut, seq);

    // MUL truncation
    wr(16'h2000, fill(16'h0100));
    wr(16'h2001, fill(16'h0100));
    cmd(16'h2003);
    repeat (4) @(negedge Clk);
    chk("trunc_cplt", 256'(Complete), 1);
    rd(16'h2002);
    chk("trunc_res", MatrixDataOut, '0);

    // busy protection: B write and ADD command during MUL are dropped
    wr(16'h2000, ident);
    wr(16'h2001, seq);
    cmd(16'h2003);
    wr(16'h2001, fill(16'h1234));
    cmd(16'h2013);
    repeat (2) @(negedge Clk);
    chk("busy_cplt", 256'(Complete), 1);
    rd(16'h2002);
    chk("busy_res", MatrixDataOut, seq);
    repeat (2) @(negedge Clk);
    chk("busy_no_add", 256'(Complete), 1);

    // reset mid-multiply while a read holds stale data on the bus
    cmd(16'h2003);
    address = 16'h2002; nRead = 0;
    repeat (2) @(negedge Clk);
    chk("pre_rst_dout", MatrixDataOut, seq);
    nReset = 0;
    #1;
    chk("async_rst_dout", MatrixDataOut, '0);
    chk("async_rst_cplt", 256'(Complete), 0);
    @(negedge Clk);
    nReset = 1;
    @(negedge Clk);
    chk("post_rst_rd", MatrixDataOut, '0);
    nRead = 1; address = '0;
    repeat (4) @(negedge Clk);
    chk("post_rst_cplt", 256'(Complete), 0);

    // unmapped writes leave A and B at zero
    wr(16'h2030, fill(16'h5555));
    wr(16'h3010, fill(16'hAAAA));
    wr(16'h2014, fill(16'h7777));
    cmd(16'h2013);
    @(negedge Clk);
    chk("unmap_cplt", 256'(Complete), 1);
    rd(16'h2012);
    chk("unmap_res", MatrixDataOut, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
